// File: rtl/spi_byte_tx.sv
// spi_byte_tx: FIFO-buffered SPI mode-3 byte transmitter (MSB first) with
// a D/C line. Ports: basys_clk/reset_n, tick enable, valid/ready byte input
// (in_data, in_dc), SPI outputs cs_n/sclk/mosi/dc, busy and FIFO level.
module spi_byte_tx #(
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic          basys_clk,
  input  logic          reset_n,
  input  logic          tick,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic          in_dc,
  output logic          cs_n,
  output logic          sclk,
  output logic          mosi,
  output logic          dc,
  output logic          busy,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t state, state_d;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic [8:0]    head;
  logic          full, empty;
  logic          push, load;

  logic [7:0] shreg, shreg_d;
  logic [2:0] bitcnt, bitcnt_d;
  logic       cs_n_d, sclk_d;
  logic       mosi_d, dc_d;

  assign full     = (count == LW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = mem[rd_ptr];
  assign level    = count;
  assign busy     = (state != IDLE) || !empty;

  always_ff @(posedge basys_clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_dc, in_data};
    end
  end

  always_ff @(posedge basys_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge basys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge basys_clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg  <= '0;
      bitcnt <= '0;
      cs_n   <= 1'b1;
      sclk   <= 1'b1;
      mosi   <= 1'b0;
      dc     <= 1'b0;
    end else begin
      shreg  <= shreg_d;
      bitcnt <= bitcnt_d;
      cs_n   <= cs_n_d;
      sclk   <= sclk_d;
      mosi   <= mosi_d;
      dc     <= dc_d;
    end
  end

  always_comb begin
    state_d  = state;
    shreg_d  = shreg;
    bitcnt_d = bitcnt;
    cs_n_d   = cs_n;
    sclk_d   = sclk;
    mosi_d   = mosi;
    dc_d     = dc;
    load     = 1'b0;

    unique case (state)
      IDLE: begin
        if (tick && !empty) begin
          load = 1'b1;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (sclk) begin
            sclk_d = 1'b0;
            // bit 7 was already presented at load
            if (bitcnt != 3'd0) begin
              shreg_d = {shreg[6:0], 1'b0};
              mosi_d  = shreg[6];
            end
          end else begin
            sclk_d = 1'b1;
            if (bitcnt == 3'd7) begin
              state_d = HOLD;
            end else begin
              bitcnt_d = bitcnt + 3'd1;
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          if (!empty) begin
            load = 1'b1;
          end else begin
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      shreg_d  = head[7:0];
      dc_d     = head[8];
      mosi_d   = head[7];
      cs_n_d   = 1'b0;
      sclk_d   = 1'b1;
      bitcnt_d = 3'd0;
      state_d  = SHIFT;
    end
  end

endmodule

// File: tb/tb_spi_byte_tx.sv
// tb_spi_byte_tx: directed and randomized checks of spi_byte_tx against
// a tick-counting transaction model and an SPI bit-capture monitor.
module tb_spi_byte_tx;

  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          basys_clk = 1'b0;
  logic          reset_n   = 1'b0;
  logic          tick      = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_dc     = 1'b0;
  logic [7:0]    in_data   = '0;
  logic          in_ready;
  logic          cs_n, sclk, mosi, dc, busy;
  logic [LW-1:0] level;

  spi_byte_tx #(.DEPTH(DEPTH), .LW(LW)) dut (
    .basys_clk (basys_clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dc     (in_dc),
    .cs_n      (cs_n),
    .sclk      (sclk),
    .mosi      (mosi),
    .dc        (dc),
    .busy      (busy),
    .level     (level)
  );

  always #5 basys_clk = ~basys_clk;

  int n_chk  = 0;
  int n_fail = 0;

  bit [8:0] expq[$];
  bit [8:0] capq[$];
  bit [7:0] msh;
  int       mcnt = 0;
  bit       mdc0;
  int       dc_err = 0;
  bit       sclk_prev = 1'b1;

  // slave-side capture: sample mosi/dc on each rising sclk while selected
  always @(negedge basys_clk) begin
    if (!reset_n) begin
      mcnt      <= 0;
      sclk_prev <= 1'b1;
    end else begin
      sclk_prev <= sclk;
      if (!sclk_prev && sclk && !cs_n) begin
        if (mcnt == 0) mdc0 <= dc;
        else if (dc !== mdc0) dc_err <= dc_err + 1;
        msh <= {msh[6:0], mosi};
        if (mcnt == 7) begin
          capq.push_back({mdc0, msh[6:0], mosi});
          mcnt <= 0;
        end else begin
          mcnt <= mcnt + 1;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge basys_clk);
    #1;
  endtask

  task automatic tk3();
    tick = 1'b1;
    clk1();
    tick = 1'b0;
    clk1();
    clk1();
  endtask

  task automatic push(input logic [7:0] d, input logic c);
    in_valid = 1'b1;
    in_data  = d;
    in_dc    = c;
    clk1();
    in_valid = 1'b0;
    expq.push_back({c, d});
  endtask

  task automatic drain();
    int k = 0;
    tick = 1'b1;
    while ((busy || !cs_n) && k < 500) begin
      clk1();
      k++;
    end
    tick = 1'b0;
    clk1();
    chk("drain_bound", k < 500, 1);
  endtask

  task automatic check_caps(input string tag);
    chk({tag, "_count"}, capq.size(), expq.size());
    while (capq.size() > 0 && expq.size() > 0)
      chk(tag, capq.pop_front(), expq.pop_front());
    capq.delete();
    expq.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick    = 1'b0;
    in_valid = 1'b0;
    clk1();
    clk1();
    reset_n = 1'b1;
    clk1();
    capq.delete();
    expq.delete();
  endtask

  initial begin
    int gaps;
    int bad;
    int occ;
    int since;
    int k;
    bit t, v, ld, pu;
    bit [7:0] rd;
    bit rc;

    // reset state
    clk1();
    clk1();
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 1);
    chk("rst_mosi", mosi, 0);
    chk("rst_dc", dc, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    clk1();

    // single byte
    push(8'hA5, 1'b1);
    chk("s_level1", level, 1);
    chk("s_busy1", busy, 1);
    chk("s_cs_pre", cs_n, 1);
    tick = 1'b1;
    clk1();
    tick = 1'b0;
    chk("s_cs_load", cs_n, 0);
    chk("s_dc_load", dc, 1);
    chk("s_mosi_load", mosi, 1);
    chk("s_sclk_load", sclk, 1);
    chk("s_level0", level, 0);
    clk1();
    clk1();
    gaps = 0;
    for (int i = 2; i <= 18; i++) begin
      tk3();
      if (i < 18 && cs_n !== 1'b0) gaps++;
    end
    chk("s_cs_low", gaps, 0);
    chk("s_cs_end", cs_n, 1);
    chk("s_busy_end", busy, 0);
    chk("s_mosi_end", mosi, 0);
    check_caps("s_byte");

    // asynchronous reset mid-byte
    push(8'h11, 1'b0);
    push(8'h22, 1'b1);
    tk3();
    chk("m_level", level, 1);
    for (int i = 0; i < 5; i++) tk3();
    #2;
    reset_n = 1'b0;
    #1;
    chk("m_cs_n", cs_n, 1);
    chk("m_level0", level, 0);
    chk("m_sclk", sclk, 1);
    chk("m_ready", in_ready, 1);
    clk1();
    clk1();
    reset_n = 1'b1;
    clk1();
    chk("m_caps", capq.size(), 0);
    capq.delete();
    expq.delete();

    // back-to-back stream
    push(8'h00, 1'b0);
    push(8'hFF, 1'b1);
    push(8'h3C, 1'b1);
    gaps = 0;
    for (int i = 1; i <= 52; i++) begin
      tk3();
      if (i < 52 && cs_n !== 1'b0) gaps++;
    end
    chk("b_cs_low", gaps, 0);
    chk("b_cs_end", cs_n, 1);
    chk("b_busy_end", busy, 0);
    check_caps("b_byte");

    // full FIFO
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h40 + 8'(i);
      in_dc    = i[0];
      #1;
      chk("f_ready", in_ready, i < 4);
      clk1();
      if (i < 4) expq.push_back({i[0], 8'h40 + 8'(i)});
    end
    chk("f_level4", level, 4);
    chk("f_ready_full", in_ready, 0);
    tick = 1'b1;
    clk1();
    tick = 1'b0;
    chk("f_level3", level, 3);
    chk("f_ready_free", in_ready, 1);
    clk1();
    in_valid = 1'b0;
    expq.push_back({1'b0, 8'h44});
    chk("f_level_refill", level, 4);
    drain();
    check_caps("f_byte");

    // push and load in the same cycle
    push(8'hC3, 1'b1);
    push(8'h96, 1'b0);
    chk("p_level2", level, 2);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    in_dc    = 1'b0;
    tick     = 1'b1;
    clk1();
    in_valid = 1'b0;
    tick     = 1'b0;
    expq.push_back({1'b0, 8'h5A});
    chk("p_level_same", level, 2);
    chk("p_cs_load", cs_n, 0);
    chk("p_dc_load", dc, 1);
    drain();
    check_caps("p_byte");

    // tick storm on empty FIFO
    do_reset();
    tick = 1'b1;
    bad  = 0;
    for (int i = 0; i < 100; i++) begin
      clk1();
      if (cs_n !== 1'b1 || sclk !== 1'b1 || mosi !== 1'b0 ||
          dc !== 1'b0 || level !== '0 || busy !== 1'b0)
        bad++;
    end
    chk("t_idle", bad, 0);
    in_valid = 1'b1;
    in_data  = 8'h81;
    in_dc    = 1'b0;
    clk1();
    in_valid = 1'b0;
    expq.push_back({1'b0, 8'h81});
    chk("t_no_bypass", cs_n, 1);
    gaps = 0;
    for (int c = 1; c <= 18; c++) begin
      clk1();
      if (c == 1) chk("t_cs_load", cs_n, 0);
      else if (c < 18 && cs_n !== 1'b0) gaps++;
    end
    tick = 1'b0;
    chk("t_cs_low", gaps, 0);
    chk("t_cs_end", cs_n, 1);
    chk("t_busy_end", busy, 0);
    clk1();
    check_caps("t_byte");

    // randomized traffic against a tick-count transaction model
    occ   = 0;
    since = -1;
    for (int n = 0; n < 1600; n++) begin
      t  = ($urandom_range(0, 1) == 1);
      v  = (n < 1400) && ($urandom_range(0, 9) < 3);
      rd = 8'($urandom);
      rc = 1'($urandom);
      tick     = t;
      in_valid = v;
      in_data  = rd;
      in_dc    = rc;
      chk("r_ready", in_ready, occ < DEPTH);
      ld = 1'b0;
      if (t) begin
        if (since < 0) begin
          if (occ > 0) ld = 1'b1;
        end else begin
          since++;
          if (since == 17) begin
            if (occ > 0) ld = 1'b1;
            else since = -1;
          end
        end
      end
      if (ld) since = 0;
      pu = v && (occ < DEPTH);
      if (pu) expq.push_back({rc, rd});
      occ = occ + int'(pu) - int'(ld);
      clk1();
      chk("r_level", level, occ);
      chk("r_busy", busy, (occ > 0) || (since >= 0));
      chk("r_cs_n", cs_n, since < 0);
    end
    in_valid = 1'b0;
    tick     = 1'b0;
    k = 0;
    while ((busy || !cs_n) && k < 1000) begin
      tick = 1'b1;
      clk1();
      k++;
    end
    tick = 1'b0;
    clk1();
    chk("r_drain_bound", k < 1000, 1);
    check_caps("r_byte");

    chk("dc_stable", dc_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_byte_tx.md
Name: spi_byte_tx

Overview:
- Serial transmitter directly downstream of the divided-clock stage. It consumes a one-cycle `tick` pulse, one per half-period of the 16.67 MHz divided clock (every 3 basys_clk cycles).
- Serialises queued bytes, each with a D/C flag, onto a 4-wire SPI link (mode 3, MSB first) for the PMOD display.
- Runs entirely in the basys_clk domain. `tick` is a clock enable, never a clock.
- A small FIFO decouples the pixel/command producer from the slow serial timing.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- LW, 3, width of `level`; must equal log2(DEPTH)+1.

Ports:
- basys_clk  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-basys_clk-cycle enable pulse; all serial activity advances only on tick=1.
- in_valid  in  1  producer has a byte.
- in_ready  out  1  FIFO not full; combinational `!full`.
- in_data  in  8  byte to send.
- in_dc  in  1  D/C flag for this byte (1 = data, 0 = command).
- cs_n  out  1  chip select, active low.
- sclk  out  1  serial clock; idles high.
- mosi  out  1  serial data.
- dc  out  1  D/C line to the display.
- busy  out  1  high when state != IDLE or FIFO is not empty.
- level  out  LW  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-byte):
  - cs_n=1, sclk=1, mosi=0, dc=0.
  - FIFO emptied, so level=0 and in_ready=1.
  - state=IDLE, bit counter=0.
- All outputs are registered except in_ready.
- FIFO:
  - Push when in_valid && in_ready, on any basys_clk edge, independent of tick.
  - Pop only on a load event (below).
  - Push and pop in the same cycle: level unchanged.
  - When full, in_ready=0 even if a pop happens that cycle; no push is accepted.
  - No bypass: a byte pushed in cycle N can be loaded no earlier than the first tick in cycle N+1 or later.
  - Pointers wrap modulo DEPTH.
- Load event (IDLE or HOLD, tick=1, FIFO non-empty):
  - Pop the head into shift reg {dc, d[7:0]}.
  - cs_n<=0, dc<=entry.dc, mosi<=d[7], sclk stays 1, bitcnt<=0.
  - Go to SHIFT.
- SHIFT, on tick:
  - If sclk=1 (falling edge): sclk<=0. If bitcnt!=0, shift and mosi<=next bit (d[7-bitcnt]).
  - If sclk=0 (rising edge, slave samples): sclk<=1. If bitcnt==7, go to HOLD; otherwise bitcnt<=bitcnt+1.
- HOLD, on tick:
  - FIFO non-empty: load event. cs_n stays 0 and dc updates at load.
  - FIFO empty: cs_n<=1, mosi<=0, go to IDLE.
- Timing:
  - One byte = 1 load tick + 16 shift ticks.
  - A back-to-back stream costs 17 ticks per byte with no cs_n gap.
  - An isolated byte takes 18 ticks from load to cs_n=1.
  - mosi and dc are stable across every rising sclk edge while cs_n=0.
- Between ticks, all serial outputs hold.
- tick is legal every cycle; behaviour is identical, just faster.
- tick while IDLE with an empty FIFO: no change.
- busy drops in the same cycle that cs_n rises with an empty FIFO.

Test Plan:
1. Reset: hold reset_n=0 → cs_n=1, sclk=1, mosi=0, dc=0, level=0, in_ready=1, busy=0. Assert reset_n=0 mid-byte (after 5 shift ticks) → cs_n=1 and level=0 immediately, with no clock edge needed.
2. Single byte: push 0xA5 with dc=1, tick every 3 cycles.
   - cs_n falls at the first tick after the push, and dc=1 there.
   - Sample mosi at the 8 sclk rising edges → 1,0,1,0,0,1,0,1.
   - cs_n=1 at the 18th tick counted from the load tick, inclusive; busy=0 then.
3. Back-to-back: push 0x00 (dc=0), 0xFF (dc=1), 0x3C (dc=1) → cs_n stays low across all 3 bytes (51 ticks). dc changes only at load ticks. Captured bytes are 0x00, 0xFF, 0x3C.
4. Full FIFO: with tick held 0, push 5 bytes → first 4 accepted, level=4, in_ready=0, 5th held. Enable tick → level drops to 3 at the load, in_ready=1, then the 5th byte is accepted.
5. Simultaneous push/pop: with level=2, push in the same cycle as a load tick → level stays 2 and the FIFO order is preserved.
6. Empty-FIFO tick storm: tick=1 every cycle with no pushes for 100 cycles → outputs stay at reset values. Then push 0x81 → a full byte completes in 17 consecutive cycles (load + 16 shift ticks), cs_n rises on the 18th, and the captured byte is 0x81.
